// File: rtl/prod_accum_sat.sv
// prod_accum_sat: accumulates a fixed window of signed products into a
// saturating signed accumulator and presents one result per window.
// The input and output sides each use a valid/ready handshake. The result
// is held under output backpressure, and no new products are taken while
// it is held.
module prod_accum_sat #(
  parameter int IN_WIDTH  = 10,
  parameter int ACC_WIDTH = 12,
  parameter int NUM_TERMS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  // The count reaches NUM_TERMS-1 at most. Keep at least one bit so that the
  // width stays legal for small windows.
  localparam int CNT_W = (NUM_TERMS > 2) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     count;
  logic                 sat_flag;

  logic [IN_WIDTH-1:0]  in_masked;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 clamp_hi;
  logic                 clamp_lo;
  logic                 clamp;
  logic [ACC_WIDTH-1:0] sum_sat;
  logic                 accept;

  // Handshake flags depend only on state and rst.
  assign in_ready  = ~rst & (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid & in_ready;

  // Sign-extended add at ACC_WIDTH+1 bits, followed by the clamp to the accumulator range.
  always_comb begin
    // NOTE: every combinational output is given a default first. A path that
    // leaves a variable unassigned would otherwise infer a latch.
    in_masked = '0;
    if (in_valid) in_masked = in_data;   // keep an idle-bus X out of the adder
    sum_wide = {acc[ACC_WIDTH-1], acc}
             + {{(ACC_WIDTH+1-IN_WIDTH){in_masked[IN_WIDTH-1]}}, in_masked};
    // If the two top bits disagree, the true sum is outside the ACC_WIDTH range.
    clamp_hi = ~sum_wide[ACC_WIDTH] &  sum_wide[ACC_WIDTH-1];
    clamp_lo =  sum_wide[ACC_WIDTH] & ~sum_wide[ACC_WIDTH-1];
    clamp    = clamp_hi | clamp_lo;
    if (clamp_hi)      sum_sat = ACC_MAX;
    else if (clamp_lo) sum_sat = ACC_MIN;
    else               sum_sat = sum_wide[ACC_WIDTH-1:0];
  end

  // Window FSM: accumulate in ACCUM, present and hold the result in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state is written with non-blocking assignments. Every
    // register then samples the values from before the edge, whatever order
    // the statements are in.
    if (rst) begin
      state    <= ST_ACCUM;
      acc      <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (clear) begin
      // Abort the window. Any held result is dropped, and out_data keeps its stale value.
      state    <= ST_ACCUM;
      acc      <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            if (count == LAST_IDX) begin
              out_data <= sum_sat;
              out_sat  <= sat_flag | clamp;
              acc      <= '0;
              count    <= '0;
              sat_flag <= 1'b0;
              state    <= ST_HOLD;
            end else begin
              acc      <= sum_sat;
              count    <= count + CNT_W'(1);
              sat_flag <= sat_flag | clamp;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) state <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule
